// File: rtl/rv_fetch_pkg.sv
// Types and helpers for the fetch stage and its decode-facing packet.
package rv_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        size_err;
    } rv_fetch_packet;

    localparam logic [31:0] RV_FETCH_STEP = 32'd4;

    function automatic logic [31:0] rv_fetch_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/rv_inst_pkg.sv
// RV32 instruction encoding helpers shared by the front end.
// Length decoding follows the standard variable-length encoding.
package rv_inst;

    typedef enum logic [2:0] {
        RV_INST_SIZE_16,
        RV_INST_SIZE_32,
        RV_INST_SIZE_48,
        RV_INST_SIZE_64,
        RV_INST_SIZE_LONG
    } rv_inst_size;

    // Length is implied by the low bits of the first 16-bit parcel.
    function automatic rv_inst_size rv_inst_get_size(input logic [15:0] header);
        if ((header & 16'h0003) != 16'h0003)
            return RV_INST_SIZE_16;
        else if ((header & 16'h001C) != 16'h001C)
            return RV_INST_SIZE_32;
        else if ((header & 16'h0020) == 16'h0000)
            return RV_INST_SIZE_48;
        else if ((header & 16'h0040) == 16'h0000)
            return RV_INST_SIZE_64;
        else
            return RV_INST_SIZE_LONG;
    endfunction

endpackage

// File: rtl/rv_fetch_stage_buffer.sv
// Small synchronous FIFO holding fetched instruction words for decode.
// Pushing into a full buffer is prevented by the owner's credit logic.
module fetch_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push)
            storage[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = storage[rd_ptr];

endmodule

// File: rtl/rv_fetch_stage.sv
// RV32 fetch stage: owns the PC, issues credit-limited word reads and
// hands in-order {pc, inst, size_err} packets to decode.
module rv_fetch_stage
    import rv_inst::*;
    import rv_fetch::*;
#(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        inst_size_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]    fetch_pc;
    logic [31:0]    out_pc;
    logic [31:0]    fifo_head;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  drop_cnt;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  outstanding;
    logic [CW:0]    credits_used;
    logic           req_fire;
    logic           resp_fire;
    logic           inst_fire;
    logic           push;
    logic           pop;
    rv_fetch_packet packet;

    // A credit covers both an in-flight read and the slot its data will occupy.
    assign credits_used  = {1'b0, inflight} + {1'b0, fifo_count};
    assign mem_req_valid = !rst && (credits_used < (CW + 1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;

    assign req_fire    = mem_req_valid && mem_req_ready;
    assign resp_fire   = mem_resp_valid && !rst;
    assign inst_fire   = inst_valid && inst_ready;
    assign outstanding = inflight + CW'(req_fire) - CW'(resp_fire);
    assign push        = resp_fire && !redirect_valid && (drop_cnt == '0);
    assign pop         = inst_fire && !redirect_valid;

    fetch_buffer #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mem_resp_data),
        .pop       (pop),
        .clear     (redirect_valid),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        packet          = '0;
        packet.pc       = out_pc;
        packet.inst     = fifo_head;
        packet.size_err = (rv_inst_get_size(fifo_head[15:0]) != RV_INST_SIZE_32);
    end

    assign inst_valid    = !rst && (fifo_count != '0);
    assign inst_pc       = packet.pc;
    assign inst_data     = packet.inst;
    assign inst_size_err = packet.size_err;

    // On redirect every read still outstanding after this edge returns stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= START_ADDR;
            out_pc   <= START_ADDR;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= outstanding;
            if (redirect_valid) begin
                fetch_pc <= rv_fetch_align(redirect_pc);
                out_pc   <= rv_fetch_align(redirect_pc);
                drop_cnt <= outstanding;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + RV_FETCH_STEP;
                if (inst_fire)
                    out_pc <= out_pc + RV_FETCH_STEP;
                if (resp_fire && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Self-checking bench for rv_fetch_stage: in-order memory model plus a
// request/packet-level reference model compared every cycle.
module tb_rv_fetch_stage;

    localparam int          DEPTH = 4;
    localparam logic [31:0] START = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        inst_size_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int lat    = 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } out_req_t;

    mem_req_t    mem_q[$];
    out_req_t    mdl_q[$];
    logic [31:0] mdl_fifo[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_out_pc;

    logic [31:0] fire_pc[$];
    logic [31:0] fire_data[$];
    logic        fire_err[$];
    int          fire_cyc[$];
    logic [31:0] req_log[$];

    always #5 clk = ~clk;

    rv_fetch_stage #(
        .START_ADDR(START),
        .DEPTH     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_pc       (inst_pc),
        .inst_data     (inst_data),
        .inst_size_err (inst_size_err)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h0000_0001;
        if (a == 32'h0000_3004) return 32'h0000_0013;
        return a;
    endfunction

    // Only the standard 32-bit length encoding is acceptable to decode.
    function automatic logic size_bad(input logic [31:0] d);
        return !(d[1:0] == 2'b11 && d[4:2] != 3'b111);
    endfunction

    function automatic logic [31:0] logged_pc(input int i);
        return (i >= 0 && i < fire_pc.size()) ? fire_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] logged_data(input int i);
        return (i >= 0 && i < fire_data.size()) ? fire_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] logged_err(input int i);
        return (i >= 0 && i < fire_err.size()) ? 32'(fire_err[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] logged_cyc(input int i);
        return (i >= 0 && i < fire_cyc.size()) ? 32'(fire_cyc[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] logged_req(input int i);
        return (i >= 0 && i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model, reference model and per-cycle compare, all mid-cycle.
    always @(negedge clk) begin
        logic exp_req;
        logic m_req;
        logic m_resp;
        logic m_pop;
        out_req_t r;
        cyc++;
        if (rst) begin
            mem_q.delete();
            mdl_q.delete();
            mdl_fifo.delete();
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
            m_fetch_pc     = START;
            m_out_pc       = START;
            checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
            checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        end else begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_data(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = 32'h0;
            end

            exp_req = (mdl_q.size() + mdl_fifo.size()) < DEPTH;
            checkOutput("req_valid", 32'(mem_req_valid), 32'(exp_req));
            if (exp_req)
                checkOutput("req_addr", mem_req_addr, m_fetch_pc);
            checkOutput("inst_valid", 32'(inst_valid), 32'(mdl_fifo.size() > 0));
            if (mdl_fifo.size() > 0) begin
                checkOutput("inst_pc", inst_pc, m_out_pc);
                checkOutput("inst_data", inst_data, mdl_fifo[0]);
                checkOutput("inst_size_err", 32'(inst_size_err), 32'(size_bad(mdl_fifo[0])));
            end

            if (mem_req_valid && mem_req_ready) begin
                mem_q.push_back('{addr: mem_req_addr, due: cyc + lat});
                req_log.push_back(mem_req_addr);
            end
            if (inst_valid && inst_ready) begin
                fire_pc.push_back(inst_pc);
                fire_data.push_back(inst_data);
                fire_err.push_back(inst_size_err);
                fire_cyc.push_back(cyc);
            end

            m_req  = exp_req && mem_req_ready;
            m_resp = mem_resp_valid;
            m_pop  = (mdl_fifo.size() > 0) && inst_ready;
            if (m_resp && mdl_q.size() > 0)
                r = mdl_q.pop_front();
            else
                r = '{addr: 32'h0, stale: 1'b1};
            if (redirect_valid) begin
                if (m_req)
                    mdl_q.push_back('{addr: m_fetch_pc, stale: 1'b1});
                foreach (mdl_q[i])
                    mdl_q[i].stale = 1'b1;
                mdl_fifo.delete();
                m_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
                m_out_pc   = redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (m_pop) begin
                    void'(mdl_fifo.pop_front());
                    m_out_pc = m_out_pc + 32'd4;
                end
                if (m_resp && !r.stale)
                    mdl_fifo.push_back(mem_data(r.addr));
                if (m_req) begin
                    mdl_q.push_back('{addr: m_fetch_pc, stale: 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] rpc,
                                 input logic mrdy, input logic irdy, input int n);
        rst            = r;
        redirect_valid = rd;
        redirect_pc    = rpc;
        mem_req_ready  = mrdy;
        inst_ready     = irdy;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        fire_pc.delete();
        fire_data.delete();
        fire_err.delete();
        fire_cyc.delete();
        req_log.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int rcyc;

        // Reset, then 1-cycle memory with decode always ready.
        applyStimulus(1, 0, 0, 1, 1, 3);
        checkOutput("reset_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("reset_inst_valid", 32'(inst_valid), 32'd0);
        clearLogs();
        applyStimulus(0, 0, 0, 1, 1, 6);
        checkOutput("first_req_addr", logged_req(0), 32'h100);
        checkOutput("stream_pc0", logged_pc(0), 32'h100);
        checkOutput("stream_pc1", logged_pc(1), 32'h104);
        checkOutput("stream_pc2", logged_pc(2), 32'h108);
        checkOutput("stream_data1", logged_data(1), 32'h104);
        checkOutput("no_bubble_01", logged_cyc(1) - logged_cyc(0), 32'd1);
        checkOutput("no_bubble_12", logged_cyc(2) - logged_cyc(1), 32'd1);

        // Decode stalled from the start: exactly DEPTH reads, head held.
        applyStimulus(1, 0, 0, 1, 0, 2);
        clearLogs();
        applyStimulus(0, 0, 0, 1, 0, 10);
        checkOutput("stall_req_count", 32'(req_log.size()), 32'd4);
        checkOutput("stall_req_valid", 32'(mem_req_valid), 32'd0);
        checkOutput("stall_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("stall_inst_pc", inst_pc, 32'h100);
        applyStimulus(0, 0, 0, 1, 1, 8);
        checkOutput("release_pc0", logged_pc(0), 32'h100);
        checkOutput("release_pc1", logged_pc(1), 32'h104);
        checkOutput("release_pc4", logged_pc(4), 32'h110);
        checkOutput("release_gapless", logged_cyc(4) - logged_cyc(0), 32'd4);

        // 3-cycle memory, redirect with three reads in flight.
        applyStimulus(1, 0, 0, 1, 1, 2);
        lat = 3;
        clearLogs();
        applyStimulus(0, 0, 0, 1, 1, 2);
        applyStimulus(0, 1, 32'h2002, 1, 1, 1);
        applyStimulus(0, 0, 0, 1, 1, 12);
        checkOutput("stale_req_addr", logged_req(2), 32'h108);
        checkOutput("redirect_req_addr", logged_req(3), 32'h2000);
        checkOutput("redirect_pc0", logged_pc(0), 32'h2000);
        checkOutput("redirect_data0", logged_data(0), 32'h2000);
        checkOutput("redirect_pc1", logged_pc(1), 32'h2004);

        // Redirect coinciding with an accepted request and a response.
        applyStimulus(1, 0, 0, 1, 1, 2);
        lat = 1;
        clearLogs();
        applyStimulus(0, 0, 0, 1, 1, 5);
        rcyc = cyc + 1;
        applyStimulus(0, 1, 32'h3000, 1, 1, 1);
        base = fire_pc.size();
        applyStimulus(0, 0, 0, 1, 1, 8);
        checkOutput("same_cycle_pc", logged_pc(base), 32'h3000);
        checkOutput("same_cycle_latency", logged_cyc(base) - 32'(rcyc), 32'd3);
        checkOutput("size16_data", logged_data(base), 32'h0000_0001);
        checkOutput("size16_err", logged_err(base), 32'd1);
        checkOutput("size32_data", logged_data(base + 1), 32'h0000_0013);
        checkOutput("size32_err", logged_err(base + 1), 32'd0);

        // Reset mid-stream with a full buffer.
        applyStimulus(1, 0, 0, 1, 1, 2);
        applyStimulus(0, 0, 0, 1, 0, 8);
        checkOutput("full_inst_valid", 32'(inst_valid), 32'd1);
        applyStimulus(1, 0, 0, 1, 0, 1);
        checkOutput("midrst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("midrst_req_valid", 32'(mem_req_valid), 32'd0);
        clearLogs();
        applyStimulus(0, 0, 0, 1, 1, 3);
        checkOutput("midrst_first_req", logged_req(0), 32'h100);

        // PC wrap with request and decode backpressure patterns.
        applyStimulus(1, 0, 0, 1, 1, 2);
        lat = 2;
        applyStimulus(0, 0, 0, 1, 1, 3);
        applyStimulus(0, 1, 32'hFFFF_FFF9, 1, 1, 1);
        base = fire_pc.size();
        for (int i = 0; i < 12; i++)
            applyStimulus(0, 0, 0, logic'(i % 3 != 2), logic'(i % 4 != 3), 1);
        applyStimulus(0, 0, 0, 1, 1, 10);
        checkOutput("wrap_pc0", logged_pc(base), 32'hFFFF_FFF8);
        checkOutput("wrap_pc1", logged_pc(base + 1), 32'hFFFF_FFFC);
        checkOutput("wrap_pc2", logged_pc(base + 2), 32'h0000_0000);
        checkOutput("wrap_pc3", logged_pc(base + 3), 32'h0000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
